cmos_region_ctrl: RTL
=====================

CMOS_REGION_CTRL -- requirements
Module: cmos_region_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- MAX_H, 640, sensor line width in pixels.
- MAX_V, 480, sensor frame height in lines.
- MIN_W, 16, minimum accepted crop width.
- MIN_H, 16, minimum accepted crop height.

REQ-002 Ports SHALL be, one per line (name direction width meaning):
- cam_pclk in 1 clock.
- rst_n in 1 asynchronous active-low reset.
- cam_vsync in 1 raw sensor frame sync; active high.
- a_req in 1 port A (host) request level.
- a_left/a_right/a_top/a_bottom in 11 each; port A region.
- a_ack out 1 port A accept/reject pulse.
- a_err out 1 port A reject flag, valid with a_ack.
- b_req, b_left/b_right/b_top/b_bottom, b_ack, b_err; port B (tracker), same as port A.
- region_config_en out 1 one-cycle commit strobe.
- region_left/right/top/bottom out 11 each; committed region.
- busy out 1 high while a region is pending.
- commit_cnt out 8 count of commits.

REQ-003 Reset SHALL be rst_n, asynchronous, active-low; the clock SHALL be cam_pclk.

Function
REQ-004 cam_vsync SHALL pass through a 2-flop synchroniser (d0, d1); vs_pos = d0 & ~d1, one cycle per frame.
REQ-005 FSM states SHALL be IDLE, PEND and COMMIT.
REQ-006 IDLE: a port is eligible when its req=1 and its ack is not asserted this cycle; the arbiter picks one eligible port per cycle.
REQ-007 Validity rule: the request is valid iff left<right, top<bottom, right<=MAX_H, bottom<=MAX_V, right-left>=MIN_W and bottom-top>=MIN_H.
- Compares are 11-bit unsigned.
- Differences are evaluated only when the ordering holds, so no wrap.
REQ-008 Valid grant: on the next edge, latch the four fields, pulse grantee ack=1 with err=0 for one cycle, and go to PEND.
REQ-009 Invalid grant: on the next edge, pulse ack=1 and err=1 for one cycle, stay in IDLE, and leave the latched and output regions unchanged.
REQ-010 The non-granted port SHALL receive no ack; it stays pending until it is granted.
REQ-011 PEND: busy=1; no grants and no acks; requests are held off. vs_pos moves to COMMIT.
REQ-012 COMMIT lasts exactly one cycle, then returns to IDLE. During it:
- region_* = latched values.
- region_config_en=1.
- commit_cnt increments, wrapping 255->0.
REQ-013 Commit latency: region_config_en SHALL be high in the cycle after the second cam_pclk edge that samples cam_vsync high after PEND is entered.
REQ-014 vs_pos while in IDLE SHALL be ignored.
REQ-015 A request granted in the same cycle as vs_pos SHALL commit at the following frame's vs_pos, never the current one.
REQ-016 region_* outputs SHALL hold their value between commits; region_config_en SHALL be 0 outside COMMIT.
REQ-017 Requesters SHALL drop req the cycle after ack. A req still high after ack is treated as a new request in the next IDLE cycle.

Reset
REQ-018 On reset, all outputs SHALL be 0:
- region_*=0, region_config_en=0, a/b ack and err=0.
- busy=0, commit_cnt=0.
REQ-019 On reset, the FSM SHALL return to IDLE, the synchroniser flops SHALL clear, and the round-robin pointer SHALL be set to "B last".
REQ-020 Reset asserted during PEND or COMMIT SHALL discard the pending region; no region_config_en SHALL follow deassertion.

Configuration
REQ-021 Macro REGION_CTRL_RR_EN:
- Defined: round-robin arbitration. On a tie, the port not granted last wins. The pointer updates on every grant, accepted or rejected.
- Undefined: fixed priority, A over B. No pointer register exists.

Verification
REQ-022 Bench SHALL cover the following directed scenarios:
- Valid commit: A requests (100,420,40,280) in IDLE -> a_ack=1, a_err=0 one cycle; busy=1. cam_vsync rises -> region_config_en single pulse with region=(100,420,40,280) and commit_cnt=1.
- Rejects: A requests (300,200,0,100) -> a_ack=1, a_err=1, busy stays 0, no commit. A requests (0,650,0,100) -> rejected. A requests (0,10,0,100) -> rejected (width 10<16).
- Tie: A and B request in the same cycle.
  - Without the macro: A granted, B acked only after the next commit.
  - With the macro, repeated ties -> grants alternate A,B,A.
- Boundary: a request accepted in the same cycle as vs_pos -> no pulse this frame; pulse at the next frame. 256 commits -> commit_cnt wraps to 0.
- Reset: rst_n asserted during PEND -> all outputs 0; after release, two vsync edges produce no region_config_en.

Source files
------------

// File: rtl/cmos_region_ctrl.sv
// Two-port crop-region controller: arbitrates host/tracker requests and commits the region on the next frame sync.
// Build option REGION_CTRL_RR_EN selects round-robin arbitration (default is fixed priority, A over B).
module cmos_region_ctrl #(
  parameter int unsigned MAX_H = 640,
  parameter int unsigned MAX_V = 480,
  parameter int unsigned MIN_W = 16,
  parameter int unsigned MIN_H = 16
) (
  input  logic        cam_pclk,
  input  logic        rst_n,
  input  logic        cam_vsync,
  input  logic        a_req,
  input  logic [10:0] a_left,
  input  logic [10:0] a_right,
  input  logic [10:0] a_top,
  input  logic [10:0] a_bottom,
  output logic        a_ack,
  output logic        a_err,
  input  logic        b_req,
  input  logic [10:0] b_left,
  input  logic [10:0] b_right,
  input  logic [10:0] b_top,
  input  logic [10:0] b_bottom,
  output logic        b_ack,
  output logic        b_err,
  output logic        region_config_en,
  output logic [10:0] region_left,
  output logic [10:0] region_right,
  output logic [10:0] region_top,
  output logic [10:0] region_bottom,
  output logic        busy,
  output logic [7:0]  commit_cnt
);

  localparam int unsigned CW = 11;
  localparam logic [CW-1:0] MAX_H_L = CW'(MAX_H);
  localparam logic [CW-1:0] MAX_V_L = CW'(MAX_V);
  localparam logic [CW-1:0] MIN_W_L = CW'(MIN_W);
  localparam logic [CW-1:0] MIN_H_L = CW'(MIN_H);

  typedef enum logic [1:0] {IDLE, PEND, COMMIT} state_t;

  state_t        state;
  logic          vs_d0, vs_d1;
  logic          vs_pos_c;
  logic          a_elig_c, b_elig_c;
  logic          grant_a_c, grant_b_c;
  logic [CW-1:0] sel_left_c, sel_right_c, sel_top_c, sel_bottom_c;
  logic          sel_ok_c;
  logic [CW-1:0] lat_left, lat_right, lat_top, lat_bottom;

  // Differences only matter once ordering holds, so the AND keeps them wrap-free.
  function automatic logic region_ok(input logic [CW-1:0] l, input logic [CW-1:0] r,
                                     input logic [CW-1:0] t, input logic [CW-1:0] b);
    logic ordered;
    ordered   = (l < r) && (t < b);
    region_ok = ordered && (r <= MAX_H_L) && (b <= MAX_V_L) &&
                ((r - l) >= MIN_W_L) && ((b - t) >= MIN_H_L);
  endfunction

  // Frame-sync synchroniser and rising-edge detect
  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d0 <= 1'b0;
      vs_d1 <= 1'b0;
    end else begin
      vs_d0 <= cam_vsync;
      vs_d1 <= vs_d0;
    end
  end

  assign vs_pos_c = vs_d0 & ~vs_d1;

  // A port that is acked this cycle has already been served.
  assign a_elig_c = a_req & ~a_ack;
  assign b_elig_c = b_req & ~b_ack;

`ifdef REGION_CTRL_RR_EN
  logic last_b;

  // B wins a tie only when A was granted last.
  assign grant_b_c = b_elig_c & (~a_elig_c | ~last_b);

  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      last_b <= 1'b1;
    end else if (state == IDLE && (grant_a_c || grant_b_c)) begin
      last_b <= grant_b_c;
    end
  end
`else
  assign grant_b_c = b_elig_c & ~a_elig_c;
`endif

  assign grant_a_c = a_elig_c & ~grant_b_c;

  always_comb begin
    sel_left_c   = a_left;
    sel_right_c  = a_right;
    sel_top_c    = a_top;
    sel_bottom_c = a_bottom;
    if (grant_b_c) begin
      sel_left_c   = b_left;
      sel_right_c  = b_right;
      sel_top_c    = b_top;
      sel_bottom_c = b_bottom;
    end
  end

  assign sel_ok_c = region_ok(sel_left_c, sel_right_c, sel_top_c, sel_bottom_c);

  // Control FSM with registered handshake and region outputs
  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      a_ack            <= 1'b0;
      a_err            <= 1'b0;
      b_ack            <= 1'b0;
      b_err            <= 1'b0;
      region_config_en <= 1'b0;
      region_left      <= '0;
      region_right     <= '0;
      region_top       <= '0;
      region_bottom    <= '0;
      busy             <= 1'b0;
      commit_cnt       <= '0;
      lat_left         <= '0;
      lat_right        <= '0;
      lat_top          <= '0;
      lat_bottom       <= '0;
    end else begin
      a_ack            <= 1'b0;
      a_err            <= 1'b0;
      b_ack            <= 1'b0;
      b_err            <= 1'b0;
      region_config_en <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_a_c || grant_b_c) begin
            a_ack <= grant_a_c;
            b_ack <= grant_b_c;
            a_err <= grant_a_c & ~sel_ok_c;
            b_err <= grant_b_c & ~sel_ok_c;
            if (sel_ok_c) begin
              lat_left   <= sel_left_c;
              lat_right  <= sel_right_c;
              lat_top    <= sel_top_c;
              lat_bottom <= sel_bottom_c;
              busy       <= 1'b1;
              state      <= PEND;
            end
          end
        end
        PEND: begin
          if (vs_pos_c) begin
            region_left      <= lat_left;
            region_right     <= lat_right;
            region_top       <= lat_top;
            region_bottom    <= lat_bottom;
            region_config_en <= 1'b1;
            commit_cnt       <= commit_cnt + 8'd1;
            state            <= COMMIT;
          end
        end
        COMMIT: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
